// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and
// a variable-latency instruction memory.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_sequencer.sv
// PC register and fetch/execute sequencer feeding a single-cycle MIPS core:
// fetches over a req/ack bus, commits for one cycle, handles halt and faults.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          TIMEOUT   = 16,
   parameter int          TIMEOUT_W = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_sequencer_if.master   imem,
   output logic [31:0]         pc,
   input  logic [31:0]         pc_new,
   output logic [31:0]         instr,
   output logic                commit,
   input  logic                halt,
   output logic                halted,
   output logic                fault,
   output logic [1:0]          fault_code,
   output logic [31:0]         retired
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [1:0]           FC_NONE      = 2'b00;
   localparam logic [1:0]           FC_MISALIGN  = 2'b01;
   localparam logic [1:0]           FC_TIMEOUT   = 2'b10;
   localparam logic [TIMEOUT_W-1:0] TMO_LAST     = TIMEOUT_W'(TIMEOUT - 1);

   state_t               state, state_nxt;
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic                 instr_load;
   logic                 pc_load;
   logic                 retire;
   logic                 tmo_clr;
   logic                 tmo_inc;
   logic                 fc_load;
   logic [1:0]           fc_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      instr_load = 1'b0;
      pc_load    = 1'b0;
      retire     = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      fc_load    = 1'b0;
      fc_nxt     = FC_NONE;
      unique case (state)
         S_FETCH: begin
            if (imem.imem_ack) begin
               instr_load = 1'b1;
               tmo_clr    = 1'b1;
               state_nxt  = S_EXEC;
            end else begin
               tmo_inc = 1'b1;
               if (tmo_cnt == TMO_LAST) begin
                  fc_load   = 1'b1;
                  fc_nxt    = FC_TIMEOUT;
                  state_nxt = S_FAULT;
               end
            end
         end
         S_EXEC: begin
            // A misaligned target still retires the current instruction,
            // and the fault takes precedence over a simultaneous halt.
            retire = 1'b1;
            if (pc_new[1:0] != 2'b00) begin
               fc_load   = 1'b1;
               fc_nxt    = FC_MISALIGN;
               state_nxt = S_FAULT;
            end else begin
               pc_load   = 1'b1;
               state_nxt = halt ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            if (!halt) state_nxt = S_FETCH;
         end
         S_FAULT: begin
            state_nxt = S_FAULT;
         end
         default: state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         instr      <= 32'h0000_0000;
         retired    <= 32'h0000_0000;
         tmo_cnt    <= '0;
         fault_code <= FC_NONE;
      end else begin
         if (pc_load)    pc         <= pc_new;
         if (instr_load) instr      <= imem.imem_rdata;
         if (retire)     retired    <= retired + 32'd1;
         if (fc_load)    fault_code <= fc_nxt;
         if (tmo_clr)      tmo_cnt <= '0;
         else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   assign imem.imem_req  = (state == S_FETCH);
   assign imem.imem_addr = pc;
   assign commit         = (state == S_EXEC);
   assign halted         = (state == S_HALT);
   assign fault          = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-sequence bench with randomized latencies, words and targets, checked
// against a transaction-level model of the fetch/execute/halt/fault rules.
module tb_fetch_sequencer;
   localparam logic [31:0] RST_PC = 32'h0040_0000;
   localparam int          TMO    = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc, pc_new, instr, retired;
   logic        commit, halt, halted, fault;
   logic [1:0]  fault_code;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_instr, m_retired;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO), .TIMEOUT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem       (bus.master),
      .pc         (pc),
      .pc_new     (pc_new),
      .instr      (instr),
      .commit     (commit),
      .halt       (halt),
      .halted     (halted),
      .fault      (fault),
      .fault_code (fault_code),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc      = RST_PC;
      m_instr   = 32'h0;
      m_retired = 32'h0;
   endtask

   task automatic chk_fetching(input string tag);
      chk({tag, "_req"},    {31'b0, bus.imem_req}, 32'd1);
      chk({tag, "_addr"},   bus.imem_addr, m_pc);
      chk({tag, "_commit"}, {31'b0, commit}, 32'd0);
      chk({tag, "_instr"},  instr, m_instr);
   endtask

   // One instruction: `delay` unacked cycles, then ack, then one EXEC cycle
   // presenting npc/hlt. Halt is randomized during FETCH where it is ignored.
   task automatic run_instr(input int delay, input logic [31:0] word,
                            input logic [31:0] npc, input logic hlt);
      for (int i = 0; i <= delay; i++) begin
         chk_fetching("fetch");
         bus.imem_ack   = (i == delay);
         bus.imem_rdata = (i == delay) ? word : $urandom;
         halt           = 1'($urandom);
         pc_new         = $urandom;
         tick();
      end
      m_instr = word;
      chk("exec_commit", {31'b0, commit}, 32'd1);
      chk("exec_instr",  instr, m_instr);
      chk("exec_req",    {31'b0, bus.imem_req}, 32'd0);
      chk("exec_pc",     pc, m_pc);
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      pc_new         = npc;
      halt           = hlt;
      tick();
      m_retired = m_retired + 32'd1;
      chk("post_retired", retired, m_retired);
      chk("post_commit",  {31'b0, commit}, 32'd0);
      if (npc[1:0] != 2'b00) begin
         chk("mis_fault", {31'b0, fault}, 32'd1);
         chk("mis_code",  {30'b0, fault_code}, 32'd1);
         chk("mis_pc",    pc, m_pc);
         chk("mis_req",   {31'b0, bus.imem_req}, 32'd0);
      end else begin
         m_pc = npc;
         chk("post_pc",     pc, m_pc);
         chk("post_halted", {31'b0, halted}, {31'b0, hlt});
         chk("post_req",    {31'b0, bus.imem_req}, {31'b0, ~hlt});
      end
      bus.imem_ack = 1'b0;
      halt         = hlt;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         bus.imem_ack   = 1'($urandom);
         bus.imem_rdata = $urandom;
         tick();
      end
      rst_n        = 1'b1;
      bus.imem_ack = 1'b0;
      halt         = 1'b0;
      model_reset();
   endtask

   task automatic chk_sticky_fault(input logic [1:0] code, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         bus.imem_ack   = 1'($urandom);
         bus.imem_rdata = $urandom;
         halt           = 1'($urandom);
         pc_new         = $urandom & 32'hFFFF_FFFC;
         tick();
         chk("sticky_fault",   {31'b0, fault}, 32'd1);
         chk("sticky_code",    {30'b0, fault_code}, {30'b0, code});
         chk("sticky_pc",      pc, m_pc);
         chk("sticky_req",     {31'b0, bus.imem_req}, 32'd0);
         chk("sticky_retired", retired, m_retired);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      halt           = 1'b0;
      pc_new         = 32'h0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      do_reset(3);

      // Reset state, first cycle after release
      chk("rst_pc",      pc, RST_PC);
      chk("rst_req",     {31'b0, bus.imem_req}, 32'd1);
      chk("rst_commit",  {31'b0, commit}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_instr",   instr, 32'd0);
      chk("rst_halted",  {31'b0, halted}, 32'd0);
      chk("rst_fault",   {31'b0, fault}, 32'd0);
      chk("rst_code",    {30'b0, fault_code}, 32'd0);

      // Zero-wait memory, sequential pc
      for (int k = 0; k < 3; k++) run_instr(0, $urandom, m_pc + 32'd4, 1'b0);
      chk("seq_retired", retired, 32'd3);
      chk("seq_pc",      pc, RST_PC + 32'd12);

      // Three-cycle ack delay
      run_instr(3, $urandom, m_pc + 32'd4, 1'b0);

      // Random latencies, words and aligned targets
      for (int k = 0; k < 25; k++)
         run_instr(int'($urandom_range(0, 5)), $urandom, $urandom & 32'hFFFF_FFFC, 1'b0);

      // Halt in EXEC, stay halted, then resume
      run_instr(int'($urandom_range(0, 3)), $urandom, $urandom & 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 4; i++) begin
         bus.imem_ack   = 1'($urandom);
         bus.imem_rdata = $urandom;
         pc_new         = $urandom & 32'hFFFF_FFFC;
         tick();
         chk("halt_halted", {31'b0, halted}, 32'd1);
         chk("halt_pc",     pc, m_pc);
         chk("halt_instr",  instr, m_instr);
         chk("halt_req",    {31'b0, bus.imem_req}, 32'd0);
      end
      halt         = 1'b0;
      bus.imem_ack = 1'b0;
      tick();
      chk("resume_halted", {31'b0, halted}, 32'd0);
      chk_fetching("resume");
      run_instr(2, $urandom, m_pc + 32'd4, 1'b0);

      // Reset in the middle of a fetch, with an ack the same cycle
      tick();
      rst_n          = 1'b0;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      tick();
      rst_n        = 1'b1;
      bus.imem_ack = 1'b0;
      model_reset();
      chk("midrst_pc",      pc, RST_PC);
      chk("midrst_instr",   instr, 32'd0);
      chk("midrst_retired", retired, 32'd0);
      chk("midrst_commit",  {31'b0, commit}, 32'd0);
      chk("midrst_req",     {31'b0, bus.imem_req}, 32'd1);

      // Fetch timeout after TMO unacked request cycles
      run_instr(1, $urandom, m_pc + 32'd8, 1'b0);
      halt = 1'b0;
      for (int i = 0; i < TMO; i++) begin
         chk("tmo_wait_req",   {31'b0, bus.imem_req}, 32'd1);
         chk("tmo_wait_fault", {31'b0, fault}, 32'd0);
         chk("tmo_wait_addr",  bus.imem_addr, m_pc);
         bus.imem_ack = 1'b0;
         halt         = 1'($urandom);
         tick();
      end
      chk("tmo_fault", {31'b0, fault}, 32'd1);
      chk("tmo_code",  {30'b0, fault_code}, 32'd2);
      chk("tmo_pc",    pc, m_pc);
      chk_sticky_fault(2'b10, 5);

      // Misaligned target, with halt asserted at the same time
      do_reset(2);
      run_instr(0, $urandom, m_pc + 32'd4, 1'b0);
      run_instr(1, $urandom, 32'h0000_0006, 1'b1);
      chk_sticky_fault(2'b01, 6);

      // Misaligned target, plain
      do_reset(1);
      run_instr(2, $urandom, 32'h0000_0001, 1'b0);
      chk_sticky_fault(2'b01, 3);

      do_reset(1);
      chk("final_pc",    pc, RST_PC);
      chk("final_fault", {31'b0, fault}, 32'd0);
      chk("final_code",  {30'b0, fault_code}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and PC-register stage directly upstream of the single-cycle MIPS core.
- Holds the architectural PC and drives it to the core's `pc` input.
- Fetches each instruction from a variable-latency instruction memory through a req/ack handshake, presents the instruction to the core for one execute cycle, then loads the core's `pc_new`.
- Also provides the commit strobe that gates register-file and data-memory writes, plus halt, fault detection and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- TIMEOUT, 16, consecutive unacknowledged fetch cycles that trigger a fault (must be ≥ 1).
- TIMEOUT_W, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- pc  output  32  current PC, to core `pc`.
- pc_new  input  32  next PC computed by core.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (equals pc).
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- instr  output  32  latched instruction, to core `instruction_memory_rd`.
- commit  output  1  high only in EXEC; external logic ANDs it with register_we3 and data_memory_we.
- halt  input  1  stop request.
- halted  output  1  high in HALT state.
- fault  output  1  high in FAULT state.
- fault_code  output  2  00 none, 01 misaligned pc_new, 10 fetch timeout.
- retired  output  32  count of committed instructions.

Behaviour:
- Reset (rst_n=0 at rising edge) has priority over all other inputs and aborts any fetch in progress. Reset values:
  - state=FETCH, pc=RESET_PC, instr=32'h0 (MIPS nop)
  - retired=0, timeout counter=0
  - fault=0, fault_code=00, halted=0, commit=0
  - imem_ack seen during reset is ignored.
- States: FETCH, EXEC, HALT, FAULT. Outputs are decoded from the registered state:
  - imem_req=1 only in FETCH.
  - commit=1 only in EXEC.
  - halted=1 only in HALT.
  - fault=1 only in FAULT.
- imem_addr=pc at all times. pc changes only at the EXEC→FETCH or EXEC→HALT transition, so the address is stable while the request is pending.
- FETCH:
  - imem_ack=1: instr<=imem_rdata, timeout counter<=0, next state EXEC.
  - imem_ack=0: counter increments. When TIMEOUT consecutive cycles have passed with no ack, the next state is FAULT with fault_code=10.
  - Minimum fetch latency is one cycle (ack in the first FETCH cycle).
- EXEC (exactly one cycle): instr is held and commit=1. At the end of the cycle:
  - pc_new[1:0]≠00: pc is not updated; next state FAULT, fault_code=01. The instruction still counts as committed, so retired increments.
  - otherwise: pc<=pc_new and retired<=retired+1. Next state is HALT if halt=1, else FETCH.
- HALT: pc and instr are frozen and no request is issued. When halt=0 is sampled, the next state is FETCH. halt is only sampled in EXEC and HALT; it is ignored in FETCH and FAULT.
- FAULT: sticky. Only reset leaves it. pc keeps the address of the faulting instruction (code 01) or the unacked fetch (code 10).
- imem_ack outside FETCH is ignored.
- retired wraps from 32'hFFFFFFFF to 0.
- Throughput with zero-wait memory: one instruction per 2 cycles.
- If halt and a misaligned pc_new occur together in EXEC, FAULT wins.

Test Plan:
- Reset, RESET_PC=32'h00400000, then release: pc=0x00400000 and imem_req=1 in the first cycle after release; commit=0, retired=0, instr=0.
- Memory acks every request immediately, core returns pc_new=pc+4:
  - commit pulses every 2nd cycle.
  - pc steps 0x00400000→0x00400004→0x00400008.
  - retired=3 after 6 cycles.
  - instr matches each imem_rdata word.
- Ack delayed 3 cycles:
  - imem_req stays high and imem_addr stays constant for 4 cycles.
  - instr changes only on the ack cycle; commit goes high the next cycle.
- pc_new=32'h00000006 during EXEC: next cycle fault=1, fault_code=01, pc unchanged, retired incremented, imem_req=0. The state persists despite later acks or halt toggles.
- No ack with TIMEOUT=16: fault=1 and fault_code=10 in the cycle after the 16th unacked request cycle. pc equals the fetch address.
- Halt and reset:
  - halt=1 in EXEC: pc<=pc_new, halted=1 next cycle, no req.
  - halt=0: FETCH resumes at the new pc.
  - rst_n=0 mid-FETCH (with imem_ack=1 the same cycle): pc=RESET_PC, instr=0, retired=0.
